// File: rtl/mc_ctrl_if.sv
// Control/handshake bundle between the multi-cycle controller and the datapath/memories.
interface mc_ctrl_if #(
  parameter int CNT_W = 32
);
  logic [31:0]      ins;
  logic             zero;
  logic             imem_ack;
  logic             dmem_ack;
  logic             imem_req;
  logic             ir_we;
  logic             dmem_req;
  logic             dmem_we;
  logic             pc_we;
  logic [1:0]       npc_sel;
  logic             reg_we;
  logic [1:0]       wa_sel;
  logic [1:0]       wd_sel;
  logic             alu_src;
  logic [1:0]       ext_op;
  logic [1:0]       alu_op;
  logic [2:0]       state;
  logic [CNT_W-1:0] retired;

  modport master (
    input  ins, zero, imem_ack, dmem_ack,
    output imem_req, ir_we, dmem_req, dmem_we, pc_we, npc_sel, reg_we,
           wa_sel, wd_sel, alu_src, ext_op, alu_op, state, retired
  );

  modport slave (
    output ins, zero, imem_ack, dmem_ack,
    input  imem_req, ir_we, dmem_req, dmem_we, pc_we, npc_sel, reg_we,
           wa_sel, wd_sel, alu_src, ext_op, alu_op, state, retired
  );
endinterface

// File: rtl/mc_ctrl.sv
// Multi-cycle MIPS main controller: FETCH/DECODE/EXEC/MEM/WB sequencing with
// wait-state tolerant memory handshakes and a retired-instruction counter.
module mc_ctrl #(
  parameter int CNT_W = 32
) (
  input  logic       clk,
  input  logic       clr,
  mc_ctrl_if.master  bus
);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4
  } state_t;

  typedef enum logic [3:0] {
    I_NOP, I_ADDU, I_SUBU, I_JR, I_ORI, I_LUI, I_LW, I_SW, I_BEQ, I_J, I_JAL
  } instr_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] retired_q, retired_d;
  instr_t           instr;

  logic       imem_req, ir_we, dmem_req, dmem_we, pc_we, reg_we;
  logic [1:0] npc_sel, wa_sel, wd_sel, ext_op, alu_op;
  logic       alu_src;

  logic [5:0] opcode, funct;
  assign opcode = bus.ins[31:26];
  assign funct  = bus.ins[5:0];

  logic unused_ins;
  assign unused_ins = &{1'b0, bus.ins[25:6]};

  always_comb begin
    instr = I_NOP;
    case (opcode)
      6'b000000: begin
        case (funct)
          6'b100001: instr = I_ADDU;
          6'b100011: instr = I_SUBU;
          6'b001000: instr = I_JR;
          default:   instr = I_NOP;
        endcase
      end
      6'b001101: instr = I_ORI;
      6'b001111: instr = I_LUI;
      6'b100011: instr = I_LW;
      6'b101011: instr = I_SW;
      6'b000100: instr = I_BEQ;
      6'b000010: instr = I_J;
      6'b000011: instr = I_JAL;
      default:   instr = I_NOP;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    imem_req = 1'b0;
    ir_we    = 1'b0;
    dmem_req = 1'b0;
    dmem_we  = 1'b0;
    pc_we    = 1'b0;
    npc_sel  = 2'd0;
    reg_we   = 1'b0;
    wa_sel   = 2'd0;
    wd_sel   = 2'd0;
    case (state_q)
      S_FETCH: begin
        imem_req = 1'b1;
        if (bus.imem_ack) begin
          ir_we   = 1'b1;
          state_d = S_DECODE;
        end
      end
      S_DECODE: state_d = S_EXEC;
      S_EXEC: begin
        case (instr)
          I_ADDU, I_SUBU, I_ORI, I_LUI: state_d = S_WB;
          I_LW, I_SW:                   state_d = S_MEM;
          I_BEQ: begin
            pc_we   = 1'b1;
            npc_sel = bus.zero ? 2'd1 : 2'd0;
            state_d = S_FETCH;
          end
          I_J: begin
            pc_we   = 1'b1;
            npc_sel = 2'd2;
            state_d = S_FETCH;
          end
          I_JAL: begin
            pc_we   = 1'b1;
            npc_sel = 2'd2;
            reg_we  = 1'b1;
            wa_sel  = 2'd2;
            wd_sel  = 2'd2;
            state_d = S_FETCH;
          end
          I_JR: begin
            pc_we   = 1'b1;
            npc_sel = 2'd3;
            state_d = S_FETCH;
          end
          default: begin
            pc_we   = 1'b1;
            state_d = S_FETCH;
          end
        endcase
      end
      S_MEM: begin
        dmem_req = 1'b1;
        dmem_we  = (instr == I_SW);
        if (bus.dmem_ack) begin
          if (instr == I_SW) begin
            pc_we   = 1'b1;
            state_d = S_FETCH;
          end else begin
            state_d = S_WB;
          end
        end
      end
      S_WB: begin
        reg_we  = 1'b1;
        pc_we   = 1'b1;
        wa_sel  = (instr == I_ADDU || instr == I_SUBU) ? 2'd0 : 2'd1;
        wd_sel  = (instr == I_LW) ? 2'd1 : 2'd0;
        state_d = S_FETCH;
      end
      default: state_d = S_FETCH;
    endcase
  end

  // ALU/extender controls depend only on the instruction, so they stay
  // constant across EXEC, MEM and WB for one instruction.
  always_comb begin
    alu_src = 1'b0;
    ext_op  = 2'd0;
    alu_op  = 2'd0;
    if (state_q == S_EXEC || state_q == S_MEM || state_q == S_WB) begin
      case (instr)
        I_SUBU: alu_op = 2'd1;
        I_ORI: begin
          alu_src = 1'b1;
          ext_op  = 2'd0;
          alu_op  = 2'd2;
        end
        I_LUI: begin
          alu_src = 1'b1;
          ext_op  = 2'd2;
        end
        I_LW, I_SW: begin
          alu_src = 1'b1;
          ext_op  = 2'd1;
        end
        default: ;
      endcase
    end
  end

  logic pc_we_g;
  assign pc_we_g   = pc_we & ~clr;
  assign retired_d = retired_q + {{(CNT_W-1){1'b0}}, pc_we_g};

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state_q   <= S_FETCH;
      retired_q <= '0;
    end else begin
      state_q   <= state_d;
      retired_q <= retired_d;
    end
  end

  // Strobes are gated by clr so an abandoned instruction never commits.
  assign bus.imem_req = imem_req & ~clr;
  assign bus.ir_we    = ir_we & ~clr;
  assign bus.dmem_req = dmem_req & ~clr;
  assign bus.dmem_we  = dmem_we & ~clr;
  assign bus.pc_we    = pc_we_g;
  assign bus.reg_we   = reg_we & ~clr;
  assign bus.npc_sel  = npc_sel;
  assign bus.wa_sel   = wa_sel;
  assign bus.wd_sel   = wd_sel;
  assign bus.alu_src  = alu_src;
  assign bus.ext_op   = ext_op;
  assign bus.alu_op   = alu_op;
  assign bus.state    = state_q;
  assign bus.retired  = retired_q;

endmodule
